pll_rst_seq: RTL and testbench
==============================

// Module: pll_rst_seq
// PURPOSE
// - Sits directly downstream of the PLL wrapper. Consumes its raw, asynchronous lock output and drives its reset input.
// - Synchronises lock, then qualifies it: lock must stay high STABLE_CYCLES consecutive cycles before it is accepted.
// - After qualification, releases NUM_RST active-high resets one at a time, in order, for the clkout0..3 consumers.
// - Controls PLL retry on lock timeout and records lock-loss events.
// PARAMETERS
// SYNC_STAGES    2      flops in the lock synchroniser (>=2)
// STABLE_CYCLES  1024   consecutive synced-high cycles required to qualify lock
// LOCK_TIMEOUT   65536  cycles in WAIT_LOCK without lock before the PLL is reset again
// PLL_RST_CYCLES 16     pll_rst_o pulse width, in cycles
// RST_GAP_CYCLES 64     cycles between successive rst_out bit releases
// NUM_RST        4      number of staged reset outputs (1..8)
// PORTS
// sys_clk          in   1        single clock domain; all logic runs on it
// sys_rst          in   1        synchronous, active-high reset
// pll_lock_in      in   1        raw PLL lock (asynchronous to sys_clk)
// clr_status       in   1        one-cycle pulse; clears lock_lost_sticky and lock_loss_cnt
// pll_rst_o        out  1        active-high reset to the PLL
// rst_out          out  NUM_RST  active-high staged resets; bit 0 releases first
// all_ready        out  1        high only in RUN (all resets released)
// lock_lost_sticky out  1        set by a lock-loss event; cleared only by clr_status or sys_rst
// lock_loss_cnt    out  8        count of lock-loss events; saturates at 255
// state_o          out  3        current FSM state encoding, for debug
// BEHAVIOUR
// - Reset values: pll_rst_o=1, rst_out=all 1, all_ready=0, lock_lost_sticky=0, lock_loss_cnt=0, state=PLL_RST, all timers 0.
// - All outputs are registered.
// - lock_s = pll_lock_in delayed by SYNC_STAGES flops. The FSM acts only on lock_s.
// - PLL_RST: pll_rst_o=1 and rst_out=all 1. After exactly PLL_RST_CYCLES cycles in this state -> WAIT_LOCK.
// - WAIT_LOCK: pll_rst_o=0 and the timeout timer counts.
//   - lock_s=1 -> STABLE.
//   - Timer reaches LOCK_TIMEOUT-1 with lock_s=0 -> PLL_RST.
//   - Lock arriving on the same cycle as the timeout: lock wins (-> STABLE).
// - STABLE: the stable counter counts while lock_s=1.
//   - Count reaches STABLE_CYCLES -> RELEASE.
//   - lock_s=0 -> WAIT_LOCK, with the timeout timer restarted from 0. This is not a loss event.
// - RELEASE: rst_out[0] goes to 0 on the first cycle of RELEASE.
//   - Each subsequent bit k goes to 0 exactly RST_GAP_CYCLES cycles after bit k-1.
//   - One cycle after rst_out[NUM_RST-1] goes to 0 -> RUN.
//   - all_ready=1 from the first RUN cycle.
// - Loss event: lock_s=0 while in RELEASE or RUN. On the next edge:
//   - rst_out=all 1, all_ready=0, state -> PLL_RST.
//   - lock_lost_sticky=1; lock_loss_cnt increments, saturating at 255.
// - clr_status alone: sticky=0, cnt=0. clr_status on the same cycle as a loss: sticky=1, cnt=1.
// - sys_rst mid-sequence: overrides everything and returns to the reset values on the next edge.
// - Once asserted by a loss, resets are never released piecemeal: a full PLL_RST -> WAIT_LOCK -> STABLE -> RELEASE pass is required.
// - Timers are sized with $clog2(param+1) bits and never wrap; each saturates at its terminal count.
// STRUCTURE
// - Package pll_rst_pkg holds:
//   - the state enum PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4;
//   - LOSS_CNT_W=8.
// - Sub-module sync_bit (parameter STAGES): a plain flop chain for pll_lock_in, with reset value 0.
// - One shared phase timer serves PLL_RST, STABLE and RELEASE. WAIT_LOCK uses a separate timeout counter.
// TESTING (STABLE_CYCLES=8, LOCK_TIMEOUT=32, PLL_RST_CYCLES=4, RST_GAP_CYCLES=4, NUM_RST=4, SYNC_STAGES=2)
// - Clean start: lock held 1 from cycle 0 after sys_rst.
//   -> pll_rst_o falls after 4 cycles.
//   -> rst_out steps 1111 -> 1110 -> 1100 -> 1000 -> 0000, 4 cycles apart.
//   -> all_ready=1 one cycle after 0000; sticky=0, cnt=0.
// - No lock: lock held 0.
//   -> pll_rst_o pulses 4 cycles wide, then stays low 32 cycles, repeatedly.
//   -> rst_out stays 1111; cnt stays 0.
// - Glitchy lock: lock high for 5 cycles, low for 1, then high.
//   -> STABLE restarts and no rst_out release occurs until 8 clean cycles.
//   -> No loss is counted.
// - Loss in RUN: drop lock for 1 cycle.
//   -> rst_out=1111 two sync cycles plus one cycle later; all_ready=0; sticky=1; cnt=1.
//   -> Full resequence follows.
// - Loss in RELEASE while rst_out=1100 -> all 1 next edge, cnt increments. 260 losses -> cnt=255.
// - clr_status coinciding with a loss -> sticky=1, cnt=1. sys_rst asserted during RELEASE -> all outputs at reset values.

Source files
------------

// File: rtl/pll_rst_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// The state encoding is visible on state_o, so the numeric values are fixed.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam int STATE_W    = 3;
  localparam int LOSS_CNT_W = 8;

  // Loss counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    return (v == {LOSS_CNT_W{1'b1}}) ? v : v + LOSS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pll_rst_seq_if.sv
// Bundle of the sequencer's PLL-facing and consumer-facing signals.
// Signalling: there are no valid/ready pairs on this bundle. pll_lock_in is a
// raw asynchronous level, clr_status is a single-cycle pulse sampled on the
// sequencer clock, and every sequencer output is a registered level that may
// be consumed at any time.
interface pll_rst_seq_if #(
  parameter int NUM_RST = 4
);
  import pll_rst_pkg::*;

  logic                  pll_lock_in;
  logic                  clr_status;
  logic                  pll_rst_o;
  logic [NUM_RST-1:0]    rst_out;
  logic                  all_ready;
  logic                  lock_lost_sticky;
  logic [LOSS_CNT_W-1:0] lock_loss_cnt;
  logic [STATE_W-1:0]    state_o;

  // The sequencer itself.
  modport master (
    input  pll_lock_in,
    input  clr_status,
    output pll_rst_o,
    output rst_out,
    output all_ready,
    output lock_lost_sticky,
    output lock_loss_cnt,
    output state_o
  );

  // The surroundings: PLL wrapper, status host and reset consumers.
  modport slave (
    output pll_lock_in,
    output clr_status,
    input  pll_rst_o,
    input  rst_out,
    input  all_ready,
    input  lock_lost_sticky,
    input  lock_loss_cnt,
    input  state_o
  );

endinterface

// File: rtl/pll_rst_seq_sync.sv
// Plain flop-chain synchroniser for a single asynchronous level.
// Output is the input delayed by STAGES flops; resets to 0 so an unknown
// lock is treated as "not locked".
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw level in at bit 0; the oldest sample leaves at the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a synchronised and
// qualified lock, then releases the staged consumer resets one by one.
// Losing lock once resets are being released pulls every consumer back into
// reset and restarts the whole sequence from a PLL reset pulse.
module pll_rst_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int PLL_RST_CYCLES = 16,
  parameter int RST_GAP_CYCLES = 64,
  parameter int NUM_RST        = 4
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  pll_rst_seq_if.master  bus
);
  import pll_rst_pkg::*;

  // The phase timer is shared by PLL_RST, STABLE and RELEASE, so it is sized
  // for the longest of the three terminal counts.
  localparam int PH_MAX_12 = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
  localparam int PH_MAX    = (PH_MAX_12 > RST_GAP_CYCLES) ? PH_MAX_12 : RST_GAP_CYCLES;
  localparam int PH_W      = $clog2(PH_MAX + 1);
  localparam int TO_W      = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [PH_W-1:0] PH_SAT     = PH_W'(PH_MAX);
  localparam logic [PH_W-1:0] PH_PLL_END = PH_W'(PLL_RST_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_STB_END = PH_W'(STABLE_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_GAP_END = PH_W'(RST_GAP_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_SAT     = TO_W'(LOCK_TIMEOUT);
  localparam logic [TO_W-1:0] TO_END     = TO_W'(LOCK_TIMEOUT - 1);

  state_t                state;
  logic [PH_W-1:0]       phase;
  logic [TO_W-1:0]       tmo;
  logic                  pll_rst_q;
  logic [NUM_RST-1:0]    rst_q;
  logic                  ready_q;
  logic                  sticky_q;
  logic [LOSS_CNT_W-1:0] cnt_q;
  logic                  lock_s;
  logic                  loss_evt;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (bus.pll_lock_in),
    .q   (lock_s)
  );

  // A loss only counts once the consumers have started to leave reset;
  // a dropout while still qualifying just restarts the qualification.
  assign loss_evt = ~lock_s & ((state == RELEASE) | (state == RUN));

  // Timers saturate at their ceiling so they can never wrap to a small value.
  function automatic logic [PH_W-1:0] ph_inc(input logic [PH_W-1:0] v);
    return (v == PH_SAT) ? v : v + PH_W'(1);
  endfunction

  function automatic logic [TO_W-1:0] to_inc(input logic [TO_W-1:0] v);
    return (v == TO_SAT) ? v : v + TO_W'(1);
  endfunction

  // Sequencer FSM: state, both timers and the registered reset/ready outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= PLL_RST;
      phase     <= '0;
      tmo       <= '0;
      pll_rst_q <= 1'b1;
      rst_q     <= '1;
      ready_q   <= 1'b0;
    end else begin
      // The timeout counter only runs in WAIT_LOCK and always restarts at 0.
      tmo <= '0;
      case (state)
        PLL_RST: begin
          if (phase == PH_PLL_END) begin
            state     <= WAIT_LOCK;
            pll_rst_q <= 1'b0;
            phase     <= '0;
          end else begin
            phase <= ph_inc(phase);
          end
        end

        WAIT_LOCK: begin
          // Lock is checked before the timeout so a lock arriving on the
          // last timeout cycle is still accepted.
          if (lock_s) begin
            state <= STABLE;
            phase <= '0;
          end else if (tmo == TO_END) begin
            state     <= PLL_RST;
            pll_rst_q <= 1'b1;
            phase     <= '0;
          end else begin
            tmo <= to_inc(tmo);
          end
        end

        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            phase <= '0;
          end else if (phase == PH_STB_END) begin
            // Bit 0 leaves reset together with the move into RELEASE.
            state <= RELEASE;
            rst_q <= rst_q << 1;
            phase <= '0;
          end else begin
            phase <= ph_inc(phase);
          end
        end

        RELEASE: begin
          if (!lock_s) begin
            state     <= PLL_RST;
            pll_rst_q <= 1'b1;
            rst_q     <= '1;
            ready_q   <= 1'b0;
            phase     <= '0;
          end else if (rst_q == '0) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end else if (phase == PH_GAP_END) begin
            // Shifting a 0 in from the bottom releases bits in index order.
            rst_q <= rst_q << 1;
            phase <= '0;
          end else begin
            phase <= ph_inc(phase);
          end
        end

        RUN: begin
          if (!lock_s) begin
            state     <= PLL_RST;
            pll_rst_q <= 1'b1;
            rst_q     <= '1;
            ready_q   <= 1'b0;
            phase     <= '0;
          end
        end

        default: begin
          state     <= PLL_RST;
          pll_rst_q <= 1'b1;
          rst_q     <= '1;
          ready_q   <= 1'b0;
          phase     <= '0;
        end
      endcase
    end
  end

  // Loss bookkeeping: a loss on the same cycle as a clear still leaves a
  // record of that one loss behind.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else if (loss_evt) begin
      sticky_q <= 1'b1;
      cnt_q    <= bus.clr_status ? LOSS_CNT_W'(1) : sat_inc(cnt_q);
    end else if (bus.clr_status) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end
  end

  assign bus.pll_rst_o        = pll_rst_q;
  assign bus.rst_out          = rst_q;
  assign bus.all_ready        = ready_q;
  assign bus.lock_lost_sticky = sticky_q;
  assign bus.lock_loss_cnt    = cnt_q;
  assign bus.state_o          = state;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq with short timing parameters.
module tb_pll_rst_seq;
  import pll_rst_pkg::*;

  localparam int NR = 4;
  localparam logic [NR-1:0] ALL1 = {NR{1'b1}};

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pll_rst_seq_if #(.NUM_RST(NR)) bus ();

  pll_rst_seq #(
    .SYNC_STAGES    (2),
    .STABLE_CYCLES  (8),
    .LOCK_TIMEOUT   (32),
    .PLL_RST_CYCLES (4),
    .RST_GAP_CYCLES (4),
    .NUM_RST        (NR)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  typedef struct packed {
    logic          pll;
    logic [NR-1:0] rout;
    logic          rdy;
    logic          sticky;
    logic [7:0]    cnt;
    logic [2:0]    st;
  } out_t;

  localparam int W = $bits(out_t);

  // One vector: inputs held for n edges, outputs expected after each edge.
  typedef struct {
    int   n;
    logic rst;
    logic lock;
    logic clr;
    out_t exp;
  } vec_t;

  vec_t           vecs[$];
  logic [W-1:0]   exp_q[$];
  int             checks = 0;
  int             errors = 0;

  // Running expectation for the loss status while the table is built.
  logic           e_sticky;
  logic [7:0]     e_cnt;

  function automatic out_t mk(state_t s, logic [NR-1:0] r, logic sk, logic [7:0] c);
    out_t o;
    o.pll    = (s == PLL_RST);
    o.rout   = r;
    o.rdy    = (s == RUN);
    o.sticky = sk;
    o.cnt    = c;
    o.st     = s;
    return o;
  endfunction

  function automatic void add(int n, logic r, logic lk, logic cl, out_t e);
    vec_t v;
    v.n    = n;
    v.rst  = r;
    v.lock = lk;
    v.clr  = cl;
    v.exp  = e;
    vecs.push_back(v);
  endfunction

  function automatic void add_reset(int n);
    e_sticky = 1'b0;
    e_cnt    = 8'd0;
    add(n, 1'b1, 1'b0, 1'b0, mk(PLL_RST, ALL1, 1'b0, 8'd0));
  endfunction

  // From the first PLL_RST cycle with lock held: 3 more PLL_RST cycles,
  // one WAIT_LOCK cycle, 8 STABLE cycles.
  function automatic void add_pre_release();
    add(3, 1'b0, 1'b1, 1'b0, mk(PLL_RST,   ALL1, e_sticky, e_cnt));
    add(1, 1'b0, 1'b1, 1'b0, mk(WAIT_LOCK, ALL1, e_sticky, e_cnt));
    add(8, 1'b0, 1'b1, 1'b0, mk(STABLE,    ALL1, e_sticky, e_cnt));
  endfunction

  function automatic void add_release_to_run(int run_n);
    add(4, 1'b0, 1'b1, 1'b0, mk(RELEASE, 4'b1110, e_sticky, e_cnt));
    add(4, 1'b0, 1'b1, 1'b0, mk(RELEASE, 4'b1100, e_sticky, e_cnt));
    add(4, 1'b0, 1'b1, 1'b0, mk(RELEASE, 4'b1000, e_sticky, e_cnt));
    add(1, 1'b0, 1'b1, 1'b0, mk(RELEASE, 4'b0000, e_sticky, e_cnt));
    add(run_n, 1'b0, 1'b1, 1'b0, mk(RUN, 4'b0000, e_sticky, e_cnt));
  endfunction

  // One-cycle lock dropout: outputs hold for two synchroniser cycles, then
  // the loss lands on the third edge (where clr may coincide).
  function automatic void add_loss(state_t s, logic [NR-1:0] r, logic cl);
    add(1, 1'b0, 1'b0, 1'b0, mk(s, r, e_sticky, e_cnt));
    add(1, 1'b0, 1'b1, 1'b0, mk(s, r, e_sticky, e_cnt));
    e_sticky = 1'b1;
    e_cnt    = cl ? 8'd1 : ((e_cnt == 8'd255) ? 8'd255 : e_cnt + 8'd1);
    add(1, 1'b0, 1'b1, cl, mk(PLL_RST, ALL1, e_sticky, e_cnt));
  endfunction

  function automatic out_t sample();
    out_t o;
    o.pll    = bus.pll_rst_o;
    o.rout   = bus.rst_out;
    o.rdy    = bus.all_ready;
    o.sticky = bus.lock_lost_sticky;
    o.cnt    = bus.lock_loss_cnt;
    o.st     = bus.state_o;
    return o;
  endfunction

  // Scoreboard compare of one cycle's outputs.
  task automatic check(int row, int k);
    out_t act;
    out_t exp;
    act = sample();
    exp = out_t'(exp_q.pop_front());
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row%0d.%0d outputs: got pll=%b rst=%b rdy=%b sticky=%b cnt=%0d state=%0d, want pll=%b rst=%b rdy=%b sticky=%b cnt=%0d state=%0d",
               row, k, act.pll, act.rout, act.rdy, act.sticky, act.cnt, act.st,
               exp.pll, exp.rout, exp.rdy, exp.sticky, exp.cnt, exp.st);
    end
  endtask

  initial begin
    bus.pll_lock_in = 1'b0;
    bus.clr_status  = 1'b0;
    e_sticky        = 1'b0;
    e_cnt           = 8'd0;

    // Reset values, then clean start with lock held high.
    add_reset(3);
    add_pre_release();
    add_release_to_run(3);

    // Loss in RUN, full resequence, then loss while rst_out=1100.
    add_loss(RUN, 4'b0000, 1'b0);
    add_pre_release();
    add(4, 1'b0, 1'b1, 1'b0, mk(RELEASE, 4'b1110, e_sticky, e_cnt));
    add_loss(RELEASE, 4'b1100, 1'b0);

    // clr_status on the loss edge leaves sticky=1, cnt=1.
    add_pre_release();
    add_loss(RELEASE, 4'b1110, 1'b1);

    // clr_status alone in RUN.
    add_pre_release();
    add_release_to_run($urandom_range(1, 4));
    e_sticky = 1'b0;
    e_cnt    = 8'd0;
    add(1, 1'b0, 1'b1, 1'b1, mk(RUN, 4'b0000, 1'b0, 8'd0));
    add($urandom_range(1, 3), 1'b0, 1'b1, 1'b0, mk(RUN, 4'b0000, 1'b0, 8'd0));

    // 260 losses saturate the counter at 255.
    add_loss(RUN, 4'b0000, 1'b0);
    for (int i = 1; i < 260; i++) begin
      add_pre_release();
      add_loss(RELEASE, 4'b1110, 1'b0);
    end

    // sys_rst in the middle of RELEASE.
    add_pre_release();
    add(4, 1'b0, 1'b1, 1'b0, mk(RELEASE, 4'b1110, e_sticky, e_cnt));
    add(2, 1'b0, 1'b1, 1'b0, mk(RELEASE, 4'b1100, e_sticky, e_cnt));
    add_reset(1);

    // Glitchy lock: high 5, low 1, then high; STABLE restarts, no loss.
    add(3, 1'b0, 1'b1, 1'b0, mk(PLL_RST,   ALL1, 1'b0, 8'd0));
    add(1, 1'b0, 1'b1, 1'b0, mk(WAIT_LOCK, ALL1, 1'b0, 8'd0));
    add(1, 1'b0, 1'b1, 1'b0, mk(STABLE,    ALL1, 1'b0, 8'd0));
    add(1, 1'b0, 1'b0, 1'b0, mk(STABLE,    ALL1, 1'b0, 8'd0));
    add(1, 1'b0, 1'b1, 1'b0, mk(STABLE,    ALL1, 1'b0, 8'd0));
    add(1, 1'b0, 1'b1, 1'b0, mk(WAIT_LOCK, ALL1, 1'b0, 8'd0));
    add(8, 1'b0, 1'b1, 1'b0, mk(STABLE,    ALL1, 1'b0, 8'd0));
    add_release_to_run(2);

    // No lock: 4-cycle PLL pulses, 32 low cycles; then lock arrives on
    // the timeout cycle and wins.
    add_reset(2);
    add(3,  1'b0, 1'b0, 1'b0, mk(PLL_RST,   ALL1, 1'b0, 8'd0));
    add(32, 1'b0, 1'b0, 1'b0, mk(WAIT_LOCK, ALL1, 1'b0, 8'd0));
    add(4,  1'b0, 1'b0, 1'b0, mk(PLL_RST,   ALL1, 1'b0, 8'd0));
    add(30, 1'b0, 1'b0, 1'b0, mk(WAIT_LOCK, ALL1, 1'b0, 8'd0));
    add(2,  1'b0, 1'b1, 1'b0, mk(WAIT_LOCK, ALL1, 1'b0, 8'd0));
    add(8,  1'b0, 1'b1, 1'b0, mk(STABLE,    ALL1, 1'b0, 8'd0));
    add_release_to_run(2);

    // Apply the table: drive, push expectation, clock, compare.
    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        rst             = vecs[i].rst;
        bus.pll_lock_in = vecs[i].lock;
        bus.clr_status  = vecs[i].clr;
        exp_q.push_back(W'(vecs[i].exp));
        @(posedge clk);
        #1;
        check(i, k);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
